fifo_wrr_drain_scheduler: RTL and testbench
===========================================

Name: fifo_wrr_drain_scheduler

Overview:
Weighted round-robin scheduler that drains NUM_CH independent FIFOs onto one valid/ready output stream. It drives each FIFO's rd_en and tracks the fixed read latency of those FIFOs. It lands returned words in an internal output buffer and uses credit-based issue, so downstream backpressure never drops data. It sits between a bank of per-channel pipelined FIFOs and a shared egress link.

Parameters:
NUM_CH, 4, number of FIFO channels (2..8)
DATA_WIDTH, 32, word width
RD_LATENCY, 2, cycles from ch_rd_en asserted to ch_rd_data valid (>=1)
WEIGHT_WIDTH, 4, bits per channel weight
OBUF_DEPTH, 4, output buffer entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new read issue
ch_empty  in  NUM_CH  per-channel FIFO empty
ch_rd_en  out  NUM_CH  per-channel read strobe, one-hot or zero
ch_rd_data  in  NUM_CH*DATA_WIDTH  per-channel read data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
weights  in  NUM_CH*WEIGHT_WIDTH  per-channel max burst; 0 = channel disabled; quasi-static
out_valid  out  1  output word available
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  output word
out_ch  out  clog2(NUM_CH)  source channel of out_data
busy  out  1  reads in flight or output buffer non-empty

Behaviour:
- Reset (rst_n=0, asynchronous): ch_rd_en=0, out_valid=0, out_data=0, out_ch=0, busy=0. cur_ch=0, burst_cnt=0, FSM=IDLE, latency pipe cleared, obuf empty.
- Eligible(i) = !ch_empty[i] && weights[i]!=0.
- Credits: outstanding = in-flight reads + obuf occupancy. Issue is allowed only when outstanding < OBUF_DEPTH. The obuf therefore never overflows.
- FSM IDLE:
  - Stays in IDLE while enable=0 or no channel is eligible.
  - Otherwise selects the first eligible channel searching cur_ch, cur_ch+1, ... (mod NUM_CH), loads cur_ch, sets burst_cnt=0 and enters SERVE. No read is issued in the selection cycle.
- FSM SERVE:
  - Each cycle with enable && Eligible(cur_ch) && credit available: ch_rd_en[cur_ch]=1 and burst_cnt increments.
  - Credit stall: remains in SERVE without issuing.
  - Leaves SERVE in the same cycle as the last issue when burst_cnt+1 == weights[cur_ch]. Also leaves when cur_ch becomes non-eligible or enable=0.
  - On leaving, cur_ch = cur_ch+1 (mod NUM_CH) and the FSM goes to IDLE; the search resumes there. This gives round-robin fairness.
- At most one ch_rd_en bit per cycle. ch_rd_en is a registered output: it asserts the cycle after the issue decision. Issue decisions use ch_empty as sampled, and the upstream FIFO deasserts empty only on real data.
- Latency pipe: a shift register of RD_LATENCY stages carrying {valid, ch id}, loaded when a read issues.
  - At the tap, ch_rd_data slice [id] is written into obuf.
  - Data arrives in issue order, so output order equals issue order.
- obuf: first-word-fall-through.
  - out_valid = !obuf_empty; out_data and out_ch come from the head entry.
  - The head pops on out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured.
  - out_data and out_ch are held stable while out_valid && !out_ready.
- enable deasserted mid-burst: no new issue from the next cycle. In-flight reads complete and drain normally.
- Weight change: takes effect at the next SERVE entry. A weight changed to 0 mid-burst ends the burst.
- busy = |pipe valids || !obuf_empty.
- Counters use modular width; cur_ch wraps from NUM_CH-1 to 0.

Optional Feature:
- Macro: FIFO_SCHED_STALL_CNT_EN.
- When defined, adds output port stall_count [15:0]. It is a saturating counter (sticks at 16'hFFFF) of cycles in SERVE with enable=1 and Eligible(cur_ch) but no credit. It resets to 0.
- When undefined, the port and the logic are absent, and behaviour is otherwise identical.

Test Plan:
- weights all 2, all channels holding 3 words, out_ready=1 → out_ch sequence 0,0,1,1,2,2,3,3,0,1,2,3. Each ch_rd_en pulse is followed by obuf write RD_LATENCY cycles later.
- weights={1,4,0,1} (ch0..ch3), all non-empty (10 words each), drain 12 words → ch2 never read; pattern 0,1,1,1,1,3 repeats.
- out_ready=0 held 20 cycles with ch0 full → exactly OBUF_DEPTH=4 reads issued and out_data stable. Releasing out_ready delivers those 4 words in write order with no loss.
- ch1 holds 1 word, weight 4 → single read, then FSM moves to ch2. No ch_rd_en is issued while ch_empty[1]=1.
- enable dropped mid-burst with 2 reads in flight → no further ch_rd_en; 2 words still emerge; busy falls to 0 after the last pop.
- rst_n asserted with reads in flight and obuf=3 → immediately out_valid=0, busy=0, ch_rd_en=0. With FIFO_SCHED_STALL_CNT_EN defined, stall_count=0 after reset and stall_count=20 after the 20-cycle backpressure test.

Source files
------------

// File: rtl/fifo_wrr_drain_scheduler_if.sv
`timescale 1ns/1ps
// fifo_wrr_drain_scheduler_if
//    Egress stream of the WRR drain scheduler: a valid/ready word stream
//    tagged with the FIFO channel the word was read from.
//
//    out_valid  word available at the head of the scheduler output buffer
//    out_ready  downstream accepts the head word this cycle
//    out_data   head word
//    out_ch     source channel of out_data
//
//    master: the scheduler (drives valid/data/ch, samples ready)
//    slave : the egress consumer
interface fifo_wrr_drain_scheduler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CH_W       = 2
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CH_W-1:0]       out_ch;

   modport master (
      output out_valid,
      output out_data,
      output out_ch,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_ch,
      output out_ready
   );
endinterface

// File: rtl/fifo_wrr_drain_scheduler.sv
`timescale 1ns/1ps
// fifo_wrr_drain_scheduler
//    Weighted round-robin scheduler draining NUM_CH pipelined FIFOs onto one
//    valid/ready stream. Reads are issued under a credit scheme that reserves
//    an output buffer slot per read, so backpressure never drops data.
//
//    clk         clock
//    rst_n       asynchronous active-low reset
//    enable      allow new read issue
//    ch_empty    per-channel FIFO empty
//    ch_rd_en    per-channel read strobe (registered, one-hot or zero)
//    ch_rd_data  per-channel read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//    weights     per-channel max burst, 0 disables the channel
//    busy        reads in flight or output buffer non-empty
//    egress      output stream (out_valid/out_ready/out_data/out_ch)
//    stall_count saturating count of credit-stalled SERVE cycles, present only
//                when FIFO_SCHED_STALL_CNT_EN is defined
module fifo_wrr_drain_scheduler #(
   parameter int NUM_CH       = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int RD_LATENCY   = 2,
   parameter int WEIGHT_WIDTH = 4,
   parameter int OBUF_DEPTH   = 4,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic [NUM_CH-1:0]                ch_empty,
   output logic [NUM_CH-1:0]                ch_rd_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_rd_data,
   input  logic [NUM_CH*WEIGHT_WIDTH-1:0]   weights,
   output logic                             busy,
   fifo_wrr_drain_scheduler_if.master       egress
`ifdef FIFO_SCHED_STALL_CNT_EN
   ,output logic [15:0]                     stall_count
`endif
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, SERVE} state_t;

   state_t                   state_q, state_d;
   logic [CH_W-1:0]          cur_ch_q, cur_ch_d, cur_ch_inc, sel_ch, rd_ch_q;
   logic [WEIGHT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d, burst_lim_q, burst_lim_d;
   logic [NUM_CH-1:0]        eligible, rd_en_q, rd_en_d;
   logic                     any_eligible, credit_ok, issue, leave, pop;
   logic [CNT_W-1:0]         outstanding_q;

   logic [WEIGHT_WIDTH-1:0]  weight_arr [NUM_CH];
   logic [DATA_WIDTH-1:0]    rd_word [NUM_CH];

   logic [RD_LATENCY-1:0]    pipe_vld;
   logic [CH_W-1:0]          pipe_ch [RD_LATENCY];

   logic [DATA_WIDTH-1:0]    obuf_data [OBUF_DEPTH];
   logic [CH_W-1:0]          obuf_ch [OBUF_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         obuf_cnt;

   // Unpack the flat per-channel buses and derive which channels may be read.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         weight_arr[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         rd_word[i]    = ch_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         eligible[i]   = !ch_empty[i] && (weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
      end
   end

   assign any_eligible = |eligible;

   // A read may only issue while every issued-but-not-popped word still has a
   // reserved output buffer slot.
   assign credit_ok  = outstanding_q < CNT_W'(OBUF_DEPTH);
   assign cur_ch_inc = (cur_ch_q == CH_W'(NUM_CH-1)) ? '0 : cur_ch_q + 1'b1;

   // Round-robin search: first eligible channel starting at cur_ch, wrapping.
   always_comb begin
      logic [CH_W:0]   sum;
      logic [CH_W-1:0] idx;
      logic            found;
      sel_ch = cur_ch_q;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum = {1'b0, cur_ch_q} + (CH_W+1)'(k);
         if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
         end
         idx = sum[CH_W-1:0];
         if (!found && eligible[idx]) begin
            sel_ch = idx;
            found  = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: IDLE only selects, SERVE issues until the burst ends.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable && any_eligible) state_d = SERVE;
         SERVE:   if (leave) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: issue decision, burst bookkeeping and channel advance.
   // The burst limit is latched on SERVE entry so weight edits only apply to
   // the next burst, while a weight dropping to 0 still ends the burst through
   // the live eligibility check.
   always_comb begin
      issue       = 1'b0;
      leave       = 1'b0;
      rd_en_d     = '0;
      cur_ch_d    = cur_ch_q;
      burst_cnt_d = burst_cnt_q;
      burst_lim_d = burst_lim_q;
      case (state_q)
         IDLE: begin
            if (enable && any_eligible) begin
               cur_ch_d    = sel_ch;
               burst_cnt_d = '0;
               burst_lim_d = weight_arr[sel_ch];
            end
         end
         SERVE: begin
            if (!enable || !eligible[cur_ch_q]) begin
               leave = 1'b1;
            end else if (credit_ok) begin
               issue             = 1'b1;
               rd_en_d[cur_ch_q] = 1'b1;
               burst_cnt_d       = burst_cnt_q + 1'b1;
               if (burst_cnt_q + 1'b1 == burst_lim_q) begin
                  leave = 1'b1;
               end
            end
            if (leave) begin
               cur_ch_d = cur_ch_inc;
            end
         end
         default: ;
      endcase
   end

   // Scheduler registers, including the registered read strobe and the id of
   // the channel it targets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_ch_q    <= '0;
         burst_cnt_q <= '0;
         burst_lim_q <= '0;
         rd_en_q     <= '0;
         rd_ch_q     <= '0;
      end else begin
         cur_ch_q    <= cur_ch_d;
         burst_cnt_q <= burst_cnt_d;
         burst_lim_q <= burst_lim_d;
         rd_en_q     <= rd_en_d;
         if (issue) begin
            rd_ch_q <= cur_ch_q;
         end
      end
   end

   // Latency pipe: starts from the cycle the strobe is on the FIFO pins, so the
   // last stage lines up with the cycle ch_rd_data is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int s = 0; s < RD_LATENCY; s++) begin
            pipe_ch[s] <= '0;
         end
      end else begin
         pipe_vld[0] <= |rd_en_q;
         pipe_ch[0]  <= rd_ch_q;
         for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_ch[s]  <= pipe_ch[s-1];
         end
      end
   end

   assign pop = egress.out_valid && egress.out_ready;

   // Output buffer (first-word-fall-through). Credits guarantee a free slot
   // for every push, so pushes are never refused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         obuf_cnt <= '0;
         for (int e = 0; e < OBUF_DEPTH; e++) begin
            obuf_data[e] <= '0;
            obuf_ch[e]   <= '0;
         end
      end else begin
         if (pipe_vld[RD_LATENCY-1]) begin
            obuf_data[wr_ptr] <= rd_word[pipe_ch[RD_LATENCY-1]];
            obuf_ch[wr_ptr]   <= pipe_ch[RD_LATENCY-1];
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (pipe_vld[RD_LATENCY-1] && !pop) begin
            obuf_cnt <= obuf_cnt + 1'b1;
         end else if (!pipe_vld[RD_LATENCY-1] && pop) begin
            obuf_cnt <= obuf_cnt - 1'b1;
         end
      end
   end

   // Outstanding words: issued reads not yet popped. This covers the strobe
   // register, the latency pipe and the buffer occupancy in one counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
      end else if (issue && !pop) begin
         outstanding_q <= outstanding_q + 1'b1;
      end else if (!issue && pop) begin
         outstanding_q <= outstanding_q - 1'b1;
      end
   end

`ifdef FIFO_SCHED_STALL_CNT_EN
   logic stall_event;
   assign stall_event = (state_q == SERVE) && enable && eligible[cur_ch_q] && !credit_ok;

   // Saturating count of cycles lost to a full credit window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall_event && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`else
   // Build without stall instrumentation: no counter and no port.
`endif

   assign ch_rd_en         = rd_en_q;
   assign busy             = outstanding_q != '0;
   assign egress.out_valid = obuf_cnt != '0;
   assign egress.out_data  = obuf_data[rd_ptr];
   assign egress.out_ch    = obuf_ch[rd_ptr];

endmodule

// File: tb/tb_fifo_wrr_drain_scheduler.sv
`timescale 1ns/1ps
// tb_fifo_wrr_drain_scheduler
//    Directed bench for fifo_wrr_drain_scheduler with a behavioural model of
//    the per-channel pipelined FIFOs. Word k of channel c carries the value
//    32'hA000_0000 | c<<16 | k, so every output word identifies its source
//    and position. Optional FIFO_SCHED_STALL_CNT_EN adds stall_count checks.
module tb_fifo_wrr_drain_scheduler;

   localparam int NUM_CH = 4;
   localparam int DW     = 32;
   localparam int LAT    = 2;
   localparam int WW     = 4;
   localparam int DEPTH  = 4;
   localparam int CH_W   = 2;

   logic                 clk     = 1'b0;
   logic                 rst_n   = 1'b0;
   logic                 enable  = 1'b0;
   logic [NUM_CH-1:0]    ch_empty;
   logic [NUM_CH-1:0]    ch_rd_en;
   logic [NUM_CH*DW-1:0] ch_rd_data;
   logic [NUM_CH*WW-1:0] weights = '0;
   logic                 busy;
`ifdef FIFO_SCHED_STALL_CNT_EN
   logic [15:0]          stall_count;
`endif

   int checks   = 0;
   int failures = 0;

   int pushed  [NUM_CH] = '{default: 0};
   int popped  [NUM_CH] = '{default: 0};
   int exp_idx [NUM_CH] = '{default: 0};
   int underflows  = 0;
   int onehot_errs = 0;
   logic [DW-1:0] dly [NUM_CH][LAT];

   int t1_seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
   int t2_pat [6]  = '{0, 1, 1, 1, 1, 3};

   fifo_wrr_drain_scheduler_if #(.DATA_WIDTH(DW), .CH_W(CH_W)) egress ();

   fifo_wrr_drain_scheduler #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .RD_LATENCY(LAT),
      .WEIGHT_WIDTH(WW), .OBUF_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .ch_empty(ch_empty),
      .ch_rd_en(ch_rd_en),
      .ch_rd_data(ch_rd_data),
      .weights(weights),
      .busy(busy),
      .egress(egress)
`ifdef FIFO_SCHED_STALL_CNT_EN
      ,.stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(input int c, input int k);
      return 32'hA000_0000 | (DW'(c) << 16) | DW'(k);
   endfunction

   // FIFO model: a strobe pops the next word, which reaches ch_rd_data LAT
   // cycles after the strobe cycle; idle slots carry a poison value.
   always @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_rd_en[i]) begin
            if (pushed[i] - popped[i] <= 0) underflows <= underflows + 1;
            dly[i][0] <= word(i, popped[i]);
            popped[i] <= popped[i] + 1;
         end else begin
            dly[i][0] <= 32'hBAD0_0000 | DW'(i);
         end
         for (int s = 1; s < LAT; s++) dly[i][s] <= dly[i][s-1];
      end
   end

   // The FIFO reports empty as soon as its last word is being read.
   always_comb begin
      ch_rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_empty[i] = (pushed[i] - popped[i] - (ch_rd_en[i] ? 1 : 0)) <= 0;
         ch_rd_data[i*DW +: DW] = dly[i][LAT-1];
      end
   end

   // Strobes must never target more than one channel at a time.
   always @(negedge clk) begin
      if (!$onehot0(ch_rd_en)) onehot_errs++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives the control inputs immediately; callers sit on a falling edge.
   task automatic applyStimulus(input logic en, input logic [NUM_CH*WW-1:0] w, input logic rdy);
      enable           = en;
      weights          = w;
      egress.out_ready = rdy;
   endtask

   task automatic loadWords(input int c, input int n);
      pushed[c] = pushed[c] + n;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n            = 1'b0;
      enable           = 1'b0;
      weights          = '0;
      egress.out_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         pushed[i]  = popped[i];
         exp_idx[i] = popped[i];
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for a word with out_ready high, checks it, lets it pop.
   task automatic checkNextWord(input int c, input string tag);
      int waitc = 0;
      while (!egress.out_valid && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      if (!egress.out_valid) begin
         checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         checkOutput({tag, "_ch"}, 64'(egress.out_ch), 64'(c));
         checkOutput({tag, "_data"}, 64'(egress.out_data), 64'(word(c, exp_idx[c])));
         exp_idx[c]++;
         @(negedge clk);
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed simulation still running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base0, base1, base2, t_rd, t_ov, cyc, p;
      logic [DW-1:0] held;
      egress.out_ready = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("rst_rd_en", 64'(ch_rd_en), 64'd0);
      checkOutput("rst_out_valid", 64'(egress.out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(egress.out_data), 64'd0);
      checkOutput("rst_out_ch", 64'(egress.out_ch), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef FIFO_SCHED_STALL_CNT_EN
      checkOutput("rst_stall_count", 64'(stall_count), 64'd0);
`endif
      rst_n = 1'b1;

      // Weights 2, three words per channel
      $display("[TB] weights 2, three words per channel");
      resetDut();
      applyStimulus(1'b1, {4{4'd2}}, 1'b1);
      for (int c = 0; c < NUM_CH; c++) loadWords(c, 3);
      t_rd = -1; t_ov = -1; cyc = 0;
      while (cyc < 50 && t_ov < 0) begin
         if (ch_rd_en != '0 && t_rd < 0) t_rd = cyc;
         if (egress.out_valid) t_ov = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("t1_rd_to_valid", 64'(t_ov - t_rd), 64'(LAT + 1));
      for (int n = 0; n < 12; n++) checkNextWord(t1_seq[n], "t1_word");
      waitIdle("t1");
      checkOutput("t1_out_valid_end", 64'(egress.out_valid), 64'd0);

      // Weights ch0=1 ch1=4 ch2=0 ch3=1
      $display("[TB] weights 1,4,0,1");
      resetDut();
      applyStimulus(1'b1, 16'h1041, 1'b1);
      for (int c = 0; c < NUM_CH; c++) loadWords(c, 12);
      base2 = popped[2];
      p = 0;
      for (int n = 0; n < 12; n++) begin
         checkNextWord(t2_pat[p % 6], "t2_word");
         p++;
      end
      applyStimulus(1'b0, 16'h1041, 1'b1);
      for (int g = 0; g < 60 && busy; g++) begin
         if (egress.out_valid) begin
            checkNextWord(t2_pat[p % 6], "t2_tail");
            p++;
         end else begin
            @(negedge clk);
         end
      end
      checkOutput("t2_ch2_reads", 64'(popped[2] - base2), 64'd0);
      waitIdle("t2");

      // Backpressure with ch0 full
      $display("[TB] backpressure on ch0");
      resetDut();
      applyStimulus(1'b1, 16'h000F, 1'b0);
      loadWords(0, 20);
      base0 = popped[0];
      repeat (6) @(negedge clk);
      held = egress.out_data;
      checkOutput("t3_valid_held", 64'(egress.out_valid), 64'd1);
      checkOutput("t3_head_word", 64'(held), 64'(word(0, exp_idx[0])));
      repeat (19) @(negedge clk);
      checkOutput("t3_data_stable", 64'(egress.out_data), 64'(held));
      checkOutput("t3_reads_issued", 64'(popped[0] - base0), 64'(DEPTH));
`ifdef FIFO_SCHED_STALL_CNT_EN
      checkOutput("t3_stall_count", 64'(stall_count), 64'd20);
`endif
      applyStimulus(1'b0, 16'h000F, 1'b1);
      for (int n = 0; n < DEPTH; n++) checkNextWord(0, "t3_word");
      checkOutput("t3_busy_after", 64'(busy), 64'd0);
      checkOutput("t3_no_extra_reads", 64'(popped[0] - base0), 64'(DEPTH));

      // Single word on ch1 then move to ch2
      $display("[TB] single word on ch1");
      resetDut();
      applyStimulus(1'b1, 16'h4444, 1'b1);
      loadWords(1, 1);
      loadWords(2, 2);
      base1 = popped[1];
      base2 = popped[2];
      checkNextWord(1, "t4_word");
      checkNextWord(2, "t4_word");
      checkNextWord(2, "t4_word");
      waitIdle("t4");
      checkOutput("t4_ch1_reads", 64'(popped[1] - base1), 64'd1);
      checkOutput("t4_ch2_reads", 64'(popped[2] - base2), 64'd2);
      checkOutput("t4_out_valid_end", 64'(egress.out_valid), 64'd0);

      // Enable dropped with two reads in flight
      $display("[TB] enable dropped mid-burst");
      resetDut();
      applyStimulus(1'b1, 16'h0008, 1'b1);
      loadWords(0, 10);
      base0 = popped[0];
      repeat (3) @(negedge clk);
      checkOutput("t5_busy_inflight", 64'(busy), 64'd1);
      applyStimulus(1'b0, 16'h0008, 1'b1);
      checkNextWord(0, "t5_word");
      checkNextWord(0, "t5_word");
      checkOutput("t5_busy_after", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      checkOutput("t5_reads", 64'(popped[0] - base0), 64'd2);
      checkOutput("t5_out_valid_end", 64'(egress.out_valid), 64'd0);

      // Reset with reads in flight and three buffered words
      $display("[TB] reset with data in flight");
      resetDut();
      applyStimulus(1'b1, 16'h000F, 1'b0);
      loadWords(0, 10);
      repeat (7) @(negedge clk);
      checkOutput("t6_busy_before", 64'(busy), 64'd1);
      checkOutput("t6_valid_before", 64'(egress.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_out_valid", 64'(egress.out_valid), 64'd0);
      checkOutput("t6_busy", 64'(busy), 64'd0);
      checkOutput("t6_rd_en", 64'(ch_rd_en), 64'd0);
`ifdef FIFO_SCHED_STALL_CNT_EN
      checkOutput("t6_stall_count", 64'(stall_count), 64'd0);
`endif
      resetDut();
      repeat (4) @(negedge clk);
      checkOutput("t6_idle_after", 64'(busy), 64'd0);

      checkOutput("onehot_violations", 64'(onehot_errs), 64'd0);
      checkOutput("fifo_underflows", 64'(underflows), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
